memory_access_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes the execute-to-memory-access pipe register (ALU result, store data, memory op, rd control).
- Performs loads and stores against the data memory through a req/gnt/rvalid handshake, holding at most one access outstanding.
- Aligns and extends load data, then registers the write-back pipe register.
- Drives a stall to the pipeline controller while an access is outstanding, and exports rd forwarding info.

---
 rtl/memory_access_stage.sv | 182 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory-access stage: one outstanding req/gnt/rvalid access, load align/extend, WB register.
// Optional: MEMORY_ACCESS_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning them.
module memory_access_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_mem_op,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_rd_we,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall,
    output logic [REG_ADDR_W-1:0] fwd_rd_addr,
    output logic                  fwd_rd_we,
    output logic                  fwd_data_pending,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic                  wb_rd_we,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_exc,
    output logic [3:0]            wb_exc_cause
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_next;
    logic            is_mem;
    logic            misalign;
    logic            req_c;
    logic            stall_c;
    logic [1:0]      a;
    logic [1:0]      a_eff;
    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data_next;

    assign is_mem = ex_valid & (ex_is_load | ex_is_store);
    assign a      = ex_alu_result[1:0];

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    assign misalign = is_mem &
                      (((ex_mem_op[1:0] == 2'b01) & a[0]) |
                       ((ex_mem_op[1:0] == 2'b10) & (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Halves and words are forced onto their natural boundary.
    always_comb begin
        a_eff = a;
        unique case (ex_mem_op[1:0])
            2'b01:   a_eff = {a[1], 1'b0};
            2'b10:   a_eff = 2'b00;
            default: a_eff = a;
        endcase
    end

    assign dmem_we   = ex_is_store;
    assign dmem_addr = {ex_alu_result[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = ex_store_data;
        unique case (ex_mem_op[1:0])
            2'b00: begin
                dmem_be    = 4'b0001 << a_eff;
                dmem_wdata = {(XLEN/8){ex_store_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = 4'b0011 << {a_eff[1], 1'b0};
                dmem_wdata = {(XLEN/16){ex_store_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = ex_store_data;
            end
        endcase
    end

    assign shamt   = {a_eff, 3'b000};
    assign shifted = dmem_rdata >> shamt;

    always_comb begin
        load_data = shifted;
        unique case (ex_mem_op[1:0])
            2'b00:   load_data = {{(XLEN-8){shifted[7] & ~ex_mem_op[2]}}, shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){shifted[15] & ~ex_mem_op[2]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        unique case (state)
            IDLE, REQ: begin
                if (is_mem && !misalign) begin
                    req_c = 1'b1;
                    if (dmem_gnt) begin
                        state_next = ex_is_load ? RESP : IDLE;
                        stall_c    = ex_is_load;
                    end else begin
                        state_next = REQ;
                        stall_c    = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (dmem_rvalid) state_next = IDLE;
                else             stall_c    = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dmem_req = req_c & rst;
    assign stall    = stall_c & rst;

    assign fwd_rd_addr      = ex_rd_addr;
    assign fwd_rd_we        = ex_valid & ex_rd_we;
    assign fwd_data_pending = ex_valid & ex_is_load &
                              ~((state == RESP) & dmem_rvalid);

    assign wb_data_next = (state == RESP) ? load_data : ex_alu_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wb_valid   <= 1'b0;
            wb_rd_addr <= '0;
            wb_rd_we   <= 1'b0;
            wb_data    <= '0;
        end else begin
            state <= state_next;
            if (stall_c) begin
                wb_valid <= 1'b0;
                wb_rd_we <= 1'b0;
            end else begin
                wb_valid   <= ex_valid;
                wb_rd_addr <= ex_rd_addr;
                wb_rd_we   <= ex_valid & ex_rd_we & ~ex_is_store & ~misalign;
                wb_data    <= wb_data_next;
            end
        end
    end

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_exc       <= 1'b0;
            wb_exc_cause <= 4'd0;
        end else if (stall_c) begin
            wb_exc       <= 1'b0;
            wb_exc_cause <= 4'd0;
        end else begin
            wb_exc       <= misalign;
            wb_exc_cause <= misalign ? (ex_is_store ? 4'd6 : 4'd4) : 4'd0;
        end
    end
`else
    assign wb_exc       = 1'b0;
    assign wb_exc_cause = 4'd0;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: loads, stores, wait states, reset, misalignment.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [4:0]  fwd_rd_addr;
    logic        fwd_rd_we, fwd_data_pending;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic [3:0]  wb_exc_cause;

    int errors = 0;
    int checks = 0;

    memory_access_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_mem_op(ex_mem_op), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall),
        .fwd_rd_addr(fwd_rd_addr), .fwd_rd_we(fwd_rd_we),
        .fwd_data_pending(fwd_data_pending), .wb_valid(wb_valid),
        .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
        .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic ld, input logic st,
                          input logic [2:0] op, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [4:0] rd, input logic we);
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_mem_op = op;
        ex_alu_result = alu; ex_store_data = sd; ex_rd_addr = rd; ex_rd_we = we;
    endtask

    // Load granted immediately, data returned the next cycle.
    task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] be,
                           input logic [31:0] exp_data);
        set_ex(1, 1, 0, op, addr, 32'h0, 5'd3, 1);
        dmem_gnt = 1'b1;
        #1;
        chk({tag, "_be"}, {28'h0, dmem_be}, {28'h0, be});
        chk({tag, "_stall0"}, {31'h0, stall}, 32'h1);
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
        #1;
        chk({tag, "_stall1"}, {31'h0, stall}, 32'h0);
        step();
        chk({tag, "_data"}, wb_data, exp_data);
        dmem_rvalid = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
    endtask

    initial begin
        rst = 1'b0;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        #12;
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b1;
        step();

        // LW 0x100, gnt now, rvalid next cycle
        set_ex(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 1);
        dmem_gnt = 1'b1;
        #1;
        chk("lw_req", {31'h0, dmem_req}, 32'h1);
        chk("lw_addr", dmem_addr, 32'h100);
        chk("lw_be", {28'h0, dmem_be}, 32'hF);
        chk("lw_stall0", {31'h0, stall}, 32'h1);
        chk("lw_pend0", {31'h0, fwd_data_pending}, 32'h1);
        step();
        chk("lw_bubble", {31'h0, wb_valid}, 32'h0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_req1", {31'h0, dmem_req}, 32'h0);
        chk("lw_stall1", {31'h0, stall}, 32'h0);
        chk("lw_pend1", {31'h0, fwd_data_pending}, 32'h0);
        step();
        chk("lw_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("lw_wb_data", wb_data, 32'hDEADBEEF);
        chk("lw_wb_rd", {27'h0, wb_rd_addr}, 32'd5);
        chk("lw_wb_we", {31'h0, wb_rd_we}, 32'h1);
        dmem_rvalid = 1'b0;

        do_load("lb", 3'b000, 32'h103, 32'h80FFFFFF, 4'b1000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h103, 32'h80FFFFFF, 4'b1000, 32'h00000080);
        do_load("lh", 3'b001, 32'h102, 32'h80010000, 4'b1100, 32'hFFFF8001);
        do_load("lhu", 3'b101, 32'h102, 32'h80010000, 4'b1100, 32'h00008001);

        // SH 0x102 with three wait states
        set_ex(1, 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 5'd9, 1);
        dmem_gnt = 1'b0;
        #1;
        chk("sh_be", {28'h0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_we", {31'h0, dmem_we}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("sh_req_wait", {31'h0, dmem_req}, 32'h1);
            chk("sh_stall_wait", {31'h0, stall}, 32'h1);
            step();
            chk("sh_bubble", {31'h0, wb_valid}, 32'h0);
        end
        dmem_gnt = 1'b1;
        #1;
        chk("sh_req_gnt", {31'h0, dmem_req}, 32'h1);
        chk("sh_stall_gnt", {31'h0, stall}, 32'h0);
        step();
        chk("sh_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("sh_wb_we", {31'h0, wb_rd_we}, 32'h0);
        dmem_gnt = 1'b0;

        // SB 0x101, granted at once
        set_ex(1, 0, 1, 3'b000, 32'h101, 32'h000000A5, 5'd1, 0);
        dmem_gnt = 1'b1;
        #1;
        chk("sb_be", {28'h0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_stall", {31'h0, stall}, 32'h0);
        step();
        chk("sb_wb_valid", {31'h0, wb_valid}, 32'h1);
        dmem_gnt = 1'b0;

        // ADD result 0x55
        set_ex(1, 0, 0, 3'b000, 32'h55, 32'h0, 5'd7, 1);
        #1;
        chk("add_req", {31'h0, dmem_req}, 32'h0);
        chk("add_stall", {31'h0, stall}, 32'h0);
        chk("add_fwd_we", {31'h0, fwd_rd_we}, 32'h1);
        chk("add_fwd_rd", {27'h0, fwd_rd_addr}, 32'd7);
        step();
        chk("add_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("add_wb_data", wb_data, 32'h55);
        chk("add_wb_we", {31'h0, wb_rd_we}, 32'h1);

        // Reset while waiting for a response, then a late rvalid
        set_ex(1, 1, 0, 3'b010, 32'h200, 32'h0, 5'd4, 1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rr_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rr_stall", {31'h0, stall}, 32'h0);
        chk("rr_req", {31'h0, dmem_req}, 32'h0);
        rst = 1'b1;
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk("rr_late_stall", {31'h0, stall}, 32'h0);
        step();
        chk("rr_late_wb", {31'h0, wb_valid}, 32'h0);
        dmem_rvalid = 1'b0;

        // LW 0x101
        set_ex(1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd6, 1);
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        #1;
        chk("mis_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_stall", {31'h0, stall}, 32'h0);
        step();
        chk("mis_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("mis_wb_we", {31'h0, wb_rd_we}, 32'h0);
        chk("mis_exc", {31'h0, wb_exc}, 32'h1);
        chk("mis_cause", {28'h0, wb_exc_cause}, 32'd4);
`else
        dmem_gnt = 1'b1;
        #1;
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_be", {28'h0, dmem_be}, 32'hF);
        chk("mis_req", {31'h0, dmem_req}, 32'h1);
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        chk("mis_wb_data", wb_data, 32'hCAFEF00D);
        chk("mis_exc", {31'h0, wb_exc}, 32'h0);
        dmem_rvalid = 1'b0;
`endif
        set_ex(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
